// File: rtl/uart_pkg.sv
// Shared types and bit-timing helper for the 8N1 UART.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int unsigned clks_per_bit(int unsigned clock_freq, int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-level handshake between the pin-mapping top and the TX/RX engines.
interface uart_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_line;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master   (output tx_data, tx_start, rx_line,
                    input  tx_ready, tx_line, rx_data, rx_valid);
  modport tx_slave (input  tx_data, tx_start, output tx_ready, tx_line);
  modport rx_slave (input  rx_line, output rx_data, rx_valid);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop input synchronizer, mid-bit sampling and stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  uart_if.rx_slave bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= bus.rx_line;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        // A low stop bit parks here until the line idles, so the break is not taken as a new start.
        if (err_q) begin
          if (sync2_q) begin
            err_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: latches a byte on request and shifts it out LSB first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  uart_if.tx_slave bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Line and ready decode straight from state so reset forces the idle level at once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    bus.tx_line  = 1'b1;
    bus.tx_ready = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        bus.tx_ready = 1'b1;
        cnt_d        = '0;
        if (bus.tx_start) begin
          data_d  = bus.tx_data;
          state_d = TX_START;
        end
      end
      TX_START: begin
        bus.tx_line = 1'b0;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        bus.tx_line = data_q[idx_q];
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/tt_um_uart_8bit.sv
// Tiny Tapeout top: maps the TT pin set onto independent UART TX and RX engines.
module tt_um_uart_8bit
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLOCK_FREQ = 10_000_000
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

  uart_if u_if ();

  assign u_if.tx_data  = ui_in;
  assign u_if.tx_start = uio_in[1];
  assign u_if.rx_line  = uio_in[0];

  uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_if.tx_slave)
  );

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (u_if.rx_slave)
  );

  assign uo_out  = u_if.rx_data;
  assign uio_out = {5'b0_0000, u_if.tx_line, u_if.tx_ready, u_if.rx_valid};
  assign uio_oe  = 8'b0000_0110;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_uart_8bit.sv
// Randomized bench for tt_um_uart_8bit against a frame-level serial model.
module tb_tt_um_uart_8bit;

  localparam int unsigned CPB = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       loopback = 1'b0;
  logic       rx_drv = 1'b1;
  logic [7:0] uo_out, uio_out, uio_oe, uio_in;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_if tb_if ();

  always #5 clk = ~clk;

  assign uio_in = {6'b00_0000, tb_if.tx_start, loopback ? uio_out[2] : rx_drv};

  tt_um_uart_8bit #(.BAUD_RATE(1_500_000), .CLOCK_FREQ(10_000_000)) dut (
    .ui_in   (tb_if.tx_data),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (1'b1),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always @(posedge clk) begin
    #1;
    if (uio_out[0] === 1'b1) rx_q.push_back(uo_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial image of one 8N1 frame: clock k of the frame carries bit k/CPB.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic send_tx(input logic [7:0] b, input string tag);
    tb_if.tx_data  = b;
    tb_if.tx_start = 1'b1;
    for (int k = 0; k < 10 * CPB; k++) begin
      tick();
      if (k == 0) begin
        check({tag, "_busy"}, uio_out[1], 1'b0);
        tb_if.tx_start = 1'b0;
      end
      if (k == 20) tb_if.tx_data = $urandom;
      check($sformatf("%s_line_k%0d", tag, k), uio_out[2], frame_bit(b, k));
    end
    tick();
    check({tag, "_ready"}, uio_out[1], 1'b1);
    check({tag, "_idle"}, uio_out[2], 1'b1);
    if (loopback) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10 * CPB; k++) begin
      rx_drv = (k / CPB == 9) ? stop : frame_bit(b, k);
      tick();
    end
    rx_drv = 1'b1;
    repeat (4) tick();
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic compare_rx(input string tag);
    repeat (10) tick();
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_hold"}, uo_out, last_good);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    tb_if.tx_data  = 8'h00;
    tb_if.tx_start = 1'b0;

    #12;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h06);
    check("rst_uio_oe", uio_oe, 8'h06);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_out", uio_out, 8'h06);
    end

    send_tx(8'h02, "tx02");
    compare_rx("no_loop");

    loopback = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_tx(8'h02, "lb02");
      send_tx(8'h0A, "lb0A");
    end
    compare_rx("loop_alt");

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_tx(b, "lb_rand");
    end
    compare_rx("loop_rand");
    loopback = 1'b0;
    repeat (4) tick();

    drive_rx(8'h55, 1'b0);
    compare_rx("frame_err");
    drive_rx(8'hA5, 1'b1);
    compare_rx("after_err");

    rx_drv = 1'b0;
    repeat (2) tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    compare_rx("glitch");
    drive_rx(8'h3C, 1'b1);
    compare_rx("after_glitch");

    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      drive_rx(b, stop);
    end
    compare_rx("rx_rand");

    b = 8'($urandom);
    tb_if.tx_data  = b;
    tb_if.tx_start = 1'b1;
    tick();
    check("mid_busy", uio_out[1], 1'b0);
    tb_if.tx_start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_line", uio_out[2], 1'b1);
    check("mid_rst_ready", uio_out[1], 1'b1);
    check("mid_rst_uo", uo_out, 8'h00);
    last_good = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send_tx(8'($urandom), "post_rst_tx");
    compare_rx("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
